mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch, scalar data and vector requesters.
// Fixed priority vector > scalar > fetch, with a starvation override for fetch.
module mem_port_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [31:0]   o_if_rdata,
    input  logic          i_d_ren,
    input  logic          i_d_wen,
    input  logic [AW-1:0] i_d_addr,
    input  logic [31:0]   i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [31:0]   o_d_rdata,
    input  logic          i_v_ren,
    input  logic          i_v_wen,
    input  logic [AW-1:0] i_v_addr,
    input  logic [31:0]   i_v_wdata,
    output logic          o_v_gnt,
    output logic          o_v_rvalid,
    output logic [31:0]   o_v_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic          o_mem_ren,
    output logic          o_mem_wen,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_stall
);
    localparam int CW = $clog2(STARVE_LIM) + 1;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2,
        TAG_V    = 2'd3
    } tag_t;

    tag_t          tag_reg, tag_next;
    logic [CW-1:0] starve_reg, starve_next;
    logic          if_gnt, d_gnt, v_gnt;
    logic          d_req, v_req, force_if;

    assign d_req    = i_d_ren | i_d_wen;
    assign v_req    = i_v_ren | i_v_wen;
    assign force_if = i_if_req && (starve_reg == CW'(STARVE_LIM));

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        v_gnt  = 1'b0;
        if (force_if)      if_gnt = 1'b1;
        else if (v_req)    v_gnt  = 1'b1;
        else if (d_req)    d_gnt  = 1'b1;
        else if (i_if_req) if_gnt = 1'b1;
    end

    // A simultaneous read+write from one requester issues only the write.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        tag_next    = TAG_NONE;
        if (if_gnt) begin
            o_mem_addr = i_if_addr;
            o_mem_ren  = 1'b1;
            tag_next   = TAG_IF;
        end else if (v_gnt) begin
            o_mem_addr  = i_v_addr;
            o_mem_wdata = i_v_wdata;
            o_mem_wen   = i_v_wen;
            o_mem_ren   = i_v_ren & ~i_v_wen;
            tag_next    = (i_v_ren & ~i_v_wen) ? TAG_V : TAG_NONE;
        end else if (d_gnt) begin
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
            o_mem_wen   = i_d_wen;
            o_mem_ren   = i_d_ren & ~i_d_wen;
            tag_next    = (i_d_ren & ~i_d_wen) ? TAG_D : TAG_NONE;
        end
    end

    always_comb begin
        starve_next = starve_reg;
        if (!i_if_req || if_gnt)
            starve_next = '0;
        else if (starve_reg < CW'(STARVE_LIM))
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg    <= TAG_NONE;
            starve_reg <= '0;
        end else begin
            tag_reg    <= tag_next;
            starve_reg <= starve_next;
        end
    end

    // Response channels: index 0 = fetch, 1 = scalar, 2 = vector (tag code gi+1).
    logic [2:0]       rvalid_all;
    logic [2:0][31:0] rdata_all;

    for (genvar gi = 0; gi < 3; gi++) begin : g_resp
        logic [31:0] hold_reg;

        assign rvalid_all[gi] = (tag_reg == tag_t'(2'(gi + 1)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                hold_reg <= '0;
            else if (rvalid_all[gi])
                hold_reg <= i_mem_rdata;
        end

        // Present RAM data live in the return cycle, then hold it.
        assign rdata_all[gi] = rvalid_all[gi] ? i_mem_rdata : hold_reg;
    end

    assign o_if_gnt    = if_gnt;
    assign o_d_gnt     = d_gnt;
    assign o_v_gnt     = v_gnt;
    assign o_if_rvalid = rvalid_all[0];
    assign o_d_rvalid  = rvalid_all[1];
    assign o_v_rvalid  = rvalid_all[2];
    assign o_if_rdata  = rdata_all[0];
    assign o_d_rdata   = rdata_all[1];
    assign o_v_rdata   = rdata_all[2];
    assign o_stall     = (d_req & ~d_gnt) | (i_if_req & ~if_gnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after the rising
// edge, outputs are checked on the falling edge.
module tb_mem_port_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt, o_if_rvalid;
    logic [31:0]   o_if_rdata;
    logic          i_d_ren, i_d_wen;
    logic [AW-1:0] i_d_addr;
    logic [31:0]   i_d_wdata;
    logic          o_d_gnt, o_d_rvalid;
    logic [31:0]   o_d_rdata;
    logic          i_v_ren, i_v_wen;
    logic [AW-1:0] i_v_addr;
    logic [31:0]   i_v_wdata;
    logic          o_v_gnt, o_v_rvalid;
    logic [31:0]   o_v_rdata;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_mem_ren, o_mem_wen;
    logic [31:0]   i_mem_rdata;
    logic          o_stall;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIM(4), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_d_ren(i_d_ren), .i_d_wen(i_d_wen), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .i_v_ren(i_v_ren), .i_v_wen(i_v_wen), .i_v_addr(i_v_addr), .i_v_wdata(i_v_wdata),
        .o_v_gnt(o_v_gnt), .o_v_rvalid(o_v_rvalid), .o_v_rdata(o_v_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .i_mem_rdata(i_mem_rdata), .o_stall(o_stall)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        i_if_req = 0; i_if_addr = '0;
        i_d_ren = 0; i_d_wen = 0; i_d_addr = '0; i_d_wdata = '0;
        i_v_ren = 0; i_v_wen = 0; i_v_addr = '0; i_v_wdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        i_mem_rdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_if_rvalid", o_if_rvalid, 0);
        check("rst_d_rvalid", o_d_rvalid, 0);
        check("rst_v_rvalid", o_v_rvalid, 0);
        check("rst_d_rdata", o_d_rdata, 0);
        check("rst_mem_ren", o_mem_ren, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_stall", o_stall, 0);
        next_cycle();
        rst = 1'b0;

        // Scalar load
        i_d_ren = 1; i_d_addr = 32'h100;
        @(negedge clk);
        $display("txn scalar load addr=100");
        check("ld_d_gnt", o_d_gnt, 1);
        check("ld_mem_ren", o_mem_ren, 1);
        check("ld_mem_addr", o_mem_addr, 32'h100);
        check("ld_stall", o_stall, 0);
        next_cycle();
        clear_reqs(); i_mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("ld_d_rvalid", o_d_rvalid, 1);
        check("ld_d_rdata", o_d_rdata, 32'hDEADBEEF);
        check("ld_if_rvalid", o_if_rvalid, 0);
        next_cycle();
        i_mem_rdata = 32'h12345678;
        @(negedge clk);
        check("ld_d_rvalid_off", o_d_rvalid, 0);
        check("ld_d_rdata_hold", o_d_rdata, 32'hDEADBEEF);

        // Fetch and scalar store together
        next_cycle();
        i_if_req = 1; i_if_addr = 32'h10;
        i_d_wen = 1; i_d_addr = 32'h200; i_d_wdata = 32'hCAFE;
        @(negedge clk);
        $display("txn fetch+store cycle0");
        check("st_d_gnt", o_d_gnt, 1);
        check("st_if_gnt", o_if_gnt, 0);
        check("st_mem_wen", o_mem_wen, 1);
        check("st_mem_ren", o_mem_ren, 0);
        check("st_mem_wdata", o_mem_wdata, 32'hCAFE);
        check("st_stall", o_stall, 1);
        next_cycle();
        i_d_wen = 0;
        @(negedge clk);
        $display("txn fetch+store cycle1");
        check("st_if_gnt1", o_if_gnt, 1);
        check("st_stall1", o_stall, 0);
        check("st_mem_addr1", o_mem_addr, 32'h10);
        check("st_d_rvalid1", o_d_rvalid, 0);
        next_cycle();
        clear_reqs(); i_mem_rdata = 32'h11112222;
        @(negedge clk);
        check("st_if_rvalid", o_if_rvalid, 1);
        check("st_if_rdata", o_if_rdata, 32'h11112222);
        check("st_d_rvalid2", o_d_rvalid, 0);

        // Starvation: vector held, fetch forced through at cycle 4
        next_cycle();
        i_v_ren = 1; i_v_addr = 32'h300; i_if_req = 1; i_if_addr = 32'h20;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            $display("txn starve cycle %0d if_gnt=%0b v_gnt=%0b", c, o_if_gnt, o_v_gnt);
            check("starve_if_gnt", o_if_gnt, (c == 4) ? 1 : 0);
            check("starve_v_gnt", o_v_gnt, (c == 4) ? 0 : 1);
            next_cycle();
        end
        clear_reqs();
        next_cycle();

        // Back-to-back reads IF, D, V
        i_if_req = 1; i_if_addr = 32'h0;
        @(negedge clk);
        $display("txn b2b IF@0");
        check("b2b_if_gnt", o_if_gnt, 1);
        check("b2b_addr0", o_mem_addr, 32'h0);
        next_cycle();
        clear_reqs(); i_d_ren = 1; i_d_addr = 32'h40; i_mem_rdata = 32'hA1;
        @(negedge clk);
        $display("txn b2b D@40");
        check("b2b_d_gnt", o_d_gnt, 1);
        check("b2b_addr1", o_mem_addr, 32'h40);
        check("b2b_if_rvalid", o_if_rvalid, 1);
        check("b2b_if_rdata", o_if_rdata, 32'hA1);
        check("b2b_c1_d_rvalid", o_d_rvalid, 0);
        check("b2b_c1_v_rvalid", o_v_rvalid, 0);
        next_cycle();
        clear_reqs(); i_v_ren = 1; i_v_addr = 32'h80; i_mem_rdata = 32'hB2;
        @(negedge clk);
        $display("txn b2b V@80");
        check("b2b_v_gnt", o_v_gnt, 1);
        check("b2b_addr2", o_mem_addr, 32'h80);
        check("b2b_d_rvalid", o_d_rvalid, 1);
        check("b2b_d_rdata", o_d_rdata, 32'hB2);
        check("b2b_c2_if_rvalid", o_if_rvalid, 0);
        check("b2b_c2_v_rvalid", o_v_rvalid, 0);
        next_cycle();
        clear_reqs(); i_mem_rdata = 32'hC3;
        @(negedge clk);
        check("b2b_v_rvalid", o_v_rvalid, 1);
        check("b2b_v_rdata", o_v_rdata, 32'hC3);
        check("b2b_c3_if_rvalid", o_if_rvalid, 0);
        check("b2b_c3_d_rvalid", o_d_rvalid, 0);
        check("b2b_if_rdata_hold", o_if_rdata, 32'hA1);

        // ren and wen together: write wins, no response
        next_cycle();
        i_d_ren = 1; i_d_wen = 1; i_d_addr = 32'h50; i_d_wdata = 32'h55;
        @(negedge clk);
        $display("txn scalar ren+wen");
        check("rw_mem_wen", o_mem_wen, 1);
        check("rw_mem_ren", o_mem_ren, 0);
        check("rw_d_gnt", o_d_gnt, 1);
        next_cycle();
        clear_reqs(); i_mem_rdata = 32'h99;
        @(negedge clk);
        check("rw_d_rvalid", o_d_rvalid, 0);
        check("rw_d_rdata_hold", o_d_rdata, 32'hB2);

        // Vector read then reset in the response cycle
        next_cycle();
        i_v_ren = 1; i_v_addr = 32'h90; i_d_ren = 1; i_d_addr = 32'h44;
        @(negedge clk);
        $display("txn vector read before reset");
        check("vr_v_gnt", o_v_gnt, 1);
        check("vr_d_gnt", o_d_gnt, 0);
        check("vr_stall", o_stall, 1);
        next_cycle();
        clear_reqs(); rst = 1'b1; i_mem_rdata = 32'h77;
        @(negedge clk);
        check("vr_rst_v_rvalid", o_v_rvalid, 0);
        check("vr_rst_v_rdata", o_v_rdata, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("vr_post_v_rvalid", o_v_rvalid, 0);
        check("vr_post_v_rdata", o_v_rdata, 0);
        check("vr_post_d_rdata", o_d_rdata, 0);
        check("vr_post_starve", dut.starve_reg, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
